// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: IF/ID/EX/MEM/WB plus branch and jump states,
// with im/dm ready handshakes and a retired-instruction counter.
package mc_ctrl_pkg;
   // Opcodes; JALR_JR is the pseudo-op the instruction register presents for JR/JALR
   localparam logic [5:0] OP_R         = 6'b000000;
   localparam logic [5:0] OP_BLTZ_BGEZ = 6'b000001;
   localparam logic [5:0] OP_J         = 6'b000010;
   localparam logic [5:0] OP_JAL       = 6'b000011;
   localparam logic [5:0] OP_BEQ       = 6'b000100;
   localparam logic [5:0] OP_BNE       = 6'b000101;
   localparam logic [5:0] OP_BLEZ      = 6'b000110;
   localparam logic [5:0] OP_BGTZ      = 6'b000111;
   localparam logic [5:0] OP_ADDI      = 6'b001000;
   localparam logic [5:0] OP_ADDIU     = 6'b001001;
   localparam logic [5:0] OP_SLTI      = 6'b001010;
   localparam logic [5:0] OP_SLTIU     = 6'b001011;
   localparam logic [5:0] OP_ANDI      = 6'b001100;
   localparam logic [5:0] OP_ORI       = 6'b001101;
   localparam logic [5:0] OP_XORI      = 6'b001110;
   localparam logic [5:0] OP_LUI       = 6'b001111;
   localparam logic [5:0] OP_JALR_JR   = 6'b010011;
   localparam logic [5:0] OP_LB        = 6'b100000;
   localparam logic [5:0] OP_LH        = 6'b100001;
   localparam logic [5:0] OP_LW        = 6'b100011;
   localparam logic [5:0] OP_LBU       = 6'b100100;
   localparam logic [5:0] OP_LHU       = 6'b100101;
   localparam logic [5:0] OP_SB        = 6'b101000;
   localparam logic [5:0] OP_SH        = 6'b101001;
   localparam logic [5:0] OP_SW        = 6'b101011;

   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_JALR = 6'b001001;

   localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
   localparam logic [1:0] ALU2REG = 2'd0, DM2REG = 2'd1, NPC2REG = 2'd2;

   localparam logic [3:0] NPC_PLUS4 = 4'd0, NPC_BRANCH_BEQ = 4'd1, NPC_BRANCH_BNE = 4'd2,
                          NPC_BRANCH_BGTZ = 4'd3, NPC_BRANCH_BLEZ = 4'd4,
                          NPC_BRANCH_BLTZ = 4'd5, NPC_BRANCH_BGEZ = 4'd6,
                          NPC_JUMP = 4'd7, NPC_JUMPR = 4'd8;

   localparam logic [4:0] ALU_NOP = 5'd0, ALU_R = 5'd1, ALU_ADD = 5'd2, ALU_ADDU = 5'd3,
                          ALU_SUB = 5'd4, ALU_AND = 5'd5, ALU_OR = 5'd6, ALU_XOR = 5'd7,
                          ALU_LUI = 5'd8, ALU_SLT = 5'd9, ALU_SLTU = 5'd10, ALU_SUBZ = 5'd11;

   localparam logic [1:0] DMWR_NOP = 2'd0, DMWR_SB = 2'd1, DMWR_SH = 2'd2, DMWR_SW = 2'd3;
   localparam logic [2:0] DMRE_NOP = 3'd0, DMRE_LB = 3'd1, DMRE_LBU = 3'd2, DMRE_LH = 3'd3,
                          DMRE_LHU = 3'd4, DMRE_LW = 3'd5;

   typedef enum logic [2:0] {
      S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
      S_WB = 3'd4, S_BR = 3'd5, S_JMP = 3'd6
   } state_t;

   typedef struct packed {
      logic       im_req;
      logic       pcwr;
      logic       pcwr_cond;
      logic       rfwr;
      logic       alusrc;
      logic       dm_req;
      logic       done;
      logic [1:0] regdst;
      logic [1:0] toreg;
      logic [1:0] dmwr;
      logic [3:0] npcop;
      logic [4:0] aluop;
      logic [2:0] dmre;
   } ctl_t;
endpackage

module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [5:0]           op,
   input  logic [5:0]           funct,
   input  logic [4:0]           bgez_bltz,
   input  logic                 im_ready,
   input  logic                 dm_ready,
   output logic                 im_req,
   output logic                 IRWr,
   output logic                 PCWr,
   output logic                 PCWrCond,
   output logic [1:0]           RegDst,
   output logic [1:0]           ToReg,
   output logic                 ALUSrc,
   output logic                 RFWr,
   output logic [3:0]           NPCOp,
   output logic [4:0]           ALUOp,
   output logic                 dm_req,
   output logic [1:0]           DMWr,
   output logic [2:0]           DMRe,
   output logic [2:0]           state,
   output logic                 instr_done,
   output logic                 illegal,
   output logic [INSTRET_W-1:0] instret
);

   function automatic logic is_load(input logic [5:0] o);
      return o inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
   endfunction

   function automatic logic is_store(input logic [5:0] o);
      return o inside {OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic logic is_imm(input logic [5:0] o);
      return o inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
   endfunction

   function automatic logic is_branch(input logic [5:0] o);
      return o inside {OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ, OP_BLTZ_BGEZ};
   endfunction

   function automatic logic is_jump(input logic [5:0] o);
      return o inside {OP_J, OP_JAL, OP_JALR_JR};
   endfunction

   function automatic state_t next_of(input state_t s, input logic [5:0] o,
                                      input logic imr, input logic dmr);
      case (s)
         S_IF:  return imr ? S_ID : S_IF;
         S_ID: begin
            if (o == OP_R || is_imm(o) || is_load(o) || is_store(o)) return S_EX;
            else if (is_branch(o))                                    return S_BR;
            else if (is_jump(o))                                      return S_JMP;
            else                                                      return S_IF;
         end
         S_EX:  return (is_load(o) || is_store(o)) ? S_MEM : S_WB;
         S_MEM: return !dmr ? S_MEM : (is_load(o) ? S_WB : S_IF);
         default: return S_IF;
      endcase
   endfunction

   function automatic logic [2:0] dmre_of(input logic [5:0] o);
      case (o)
         OP_LB:   return DMRE_LB;
         OP_LBU:  return DMRE_LBU;
         OP_LH:   return DMRE_LH;
         OP_LHU:  return DMRE_LHU;
         OP_LW:   return DMRE_LW;
         default: return DMRE_NOP;
      endcase
   endfunction

   function automatic logic [1:0] dmwr_of(input logic [5:0] o);
      case (o)
         OP_SB:   return DMWR_SB;
         OP_SH:   return DMWR_SH;
         OP_SW:   return DMWR_SW;
         default: return DMWR_NOP;
      endcase
   endfunction

   function automatic logic [4:0] aluop_ex(input logic [5:0] o);
      case (o)
         OP_R:     return ALU_R;
         OP_ADDIU: return ALU_ADDU;
         OP_ANDI:  return ALU_AND;
         OP_ORI:   return ALU_OR;
         OP_XORI:  return ALU_XOR;
         OP_LUI:   return ALU_LUI;
         OP_SLTI:  return ALU_SLT;
         OP_SLTIU: return ALU_SLTU;
         default:  return ALU_ADD;
      endcase
   endfunction

   function automatic logic [3:0] npc_br(input logic [5:0] o, input logic [4:0] bz);
      case (o)
         OP_BEQ:  return NPC_BRANCH_BEQ;
         OP_BNE:  return NPC_BRANCH_BNE;
         OP_BGTZ: return NPC_BRANCH_BGTZ;
         OP_BLEZ: return NPC_BRANCH_BLEZ;
         default: return (bz == 5'b00000) ? NPC_BRANCH_BLTZ : NPC_BRANCH_BGEZ;
      endcase
   endfunction

   // Control word for the state about to be entered, so every output comes straight off a flop
   function automatic ctl_t decode(input state_t s, input logic [5:0] o,
                                   input logic [5:0] f, input logic [4:0] bz);
      ctl_t c;
      c        = '0;
      c.regdst = RD_RT;
      c.toreg  = ALU2REG;
      c.npcop  = NPC_PLUS4;
      c.aluop  = ALU_NOP;
      c.dmwr   = DMWR_NOP;
      c.dmre   = DMRE_NOP;
      case (s)
         S_IF: c.im_req = 1'b1;
         S_EX: begin
            c.alusrc = (o != OP_R);
            c.aluop  = aluop_ex(o);
         end
         S_MEM: begin
            c.dm_req = 1'b1;
            c.alusrc = 1'b1;
            c.aluop  = ALU_ADD;
            c.dmre   = dmre_of(o);
            c.dmwr   = dmwr_of(o);
         end
         S_WB: begin
            c.rfwr = 1'b1;
            c.done = 1'b1;
            if (o == OP_R) c.regdst = RD_RD;
            if (is_load(o)) begin
               c.toreg = DM2REG;
               c.dmre  = dmre_of(o);
            end
         end
         S_BR: begin
            c.pcwr_cond = 1'b1;
            c.done      = 1'b1;
            c.aluop     = (o == OP_BEQ || o == OP_BNE) ? ALU_SUB : ALU_SUBZ;
            c.npcop     = npc_br(o, bz);
         end
         S_JMP: begin
            c.pcwr  = 1'b1;
            c.done  = 1'b1;
            c.npcop = (o == OP_JALR_JR) ? NPC_JUMPR : NPC_JUMP;
            if (o == OP_JAL) begin
               c.rfwr   = 1'b1;
               c.regdst = RD_RA;
               c.toreg  = NPC2REG;
            end else if (o == OP_JALR_JR && f == F_JALR) begin
               c.rfwr   = 1'b1;
               c.regdst = RD_RD;
               c.toreg  = NPC2REG;
            end
         end
         default: ;
      endcase
      return c;
   endfunction

   state_t cur, nxt;
   ctl_t   ctl;
   logic   fetch_hit;

   assign nxt       = next_of(cur, op, im_ready, dm_ready);
   assign fetch_hit = !rst && cur == S_IF && im_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur     <= S_IF;
         ctl     <= decode(S_IF, 6'd0, 6'd0, 5'd0);
         instret <= '0;
      end else begin
         cur <= nxt;
         ctl <= decode(nxt, op, funct, bgez_bltz);
         if (instr_done) instret <= instret + INSTRET_W'(1);
      end
   end

   // Only the ready-qualified strobes and the S_ID illegal flag are combinational
   assign IRWr       = fetch_hit;
   assign PCWr       = ctl.pcwr | fetch_hit;
   assign instr_done = ctl.done | (!rst && cur == S_MEM && is_store(op) && dm_ready);
   assign illegal    = !rst && cur == S_ID && !(op == OP_R || is_imm(op) || is_load(op) ||
                                               is_store(op) || is_branch(op) || is_jump(op));

   assign im_req   = ctl.im_req;
   assign PCWrCond = ctl.pcwr_cond;
   assign RegDst   = ctl.regdst;
   assign ToReg    = ctl.toreg;
   assign ALUSrc   = ctl.alusrc;
   assign RFWr     = ctl.rfwr;
   assign NPCOp    = ctl.npcop;
   assign ALUOp    = ctl.aluop;
   assign dm_req   = ctl.dm_req;
   assign DMWr     = ctl.dmwr;
   assign DMRe     = ctl.dmre;
   assign state    = cur;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-scenario tasks with hand-computed state sequences and strobes.
module tb_mc_ctrl_fsm;
   import mc_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op, funct;
   logic [4:0] bgez_bltz;
   logic       im_ready, dm_ready;
   logic       im_req, IRWr, PCWr, PCWrCond, ALUSrc, RFWr, dm_req, instr_done, illegal;
   logic [1:0] RegDst, ToReg, DMWr;
   logic [3:0] NPCOp;
   logic [4:0] ALUOp;
   logic [2:0] DMRe, state;
   logic [2:0] instret;

   int         n_cmp = 0, n_err = 0;
   logic [2:0] exp_ret;

   mc_ctrl_fsm #(.INSTRET_W(3)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .bgez_bltz(bgez_bltz),
      .im_ready(im_ready), .dm_ready(dm_ready), .im_req(im_req), .IRWr(IRWr),
      .PCWr(PCWr), .PCWrCond(PCWrCond), .RegDst(RegDst), .ToReg(ToReg),
      .ALUSrc(ALUSrc), .RFWr(RFWr), .NPCOp(NPCOp), .ALUOp(ALUOp), .dm_req(dm_req),
      .DMWr(DMWr), .DMRe(DMRe), .state(state), .instr_done(instr_done),
      .illegal(illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (state !== 3'd0)      begin n_err++; $display("FAIL rst_state got %0d exp 0", state); end
      n_cmp++; if (im_req !== 1'b1)     begin n_err++; $display("FAIL rst_im_req got %b exp 1", im_req); end
      n_cmp++; if (IRWr !== 1'b0 || PCWr !== 1'b0 || RFWr !== 1'b0 || dm_req !== 1'b0 || PCWrCond !== 1'b0)
                  begin n_err++; $display("FAIL rst_strobes got IRWr%b PCWr%b RFWr%b dm%b cond%b exp all 0", IRWr, PCWr, RFWr, dm_req, PCWrCond); end
      n_cmp++; if (instret !== 3'd0)    begin n_err++; $display("FAIL rst_instret got %0d exp 0", instret); end
      n_cmp++; if (NPCOp !== NPC_PLUS4 || ALUOp !== ALU_NOP || DMWr !== DMWR_NOP || DMRe !== DMRE_NOP)
                  begin n_err++; $display("FAIL rst_fields got npc%0d alu%0d dmwr%0d dmre%0d exp defaults", NPCOp, ALUOp, DMWr, DMRe); end
      rst = 1'b0; im_ready = 1'b1; dm_ready = 1'b1;
      exp_ret = 3'd0;
   endtask

   task automatic test_addi;
      int st[5] = '{0, 1, 2, 4, 0};
      op = OP_ADDI;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++; if (state !== 3'(st[c])) begin n_err++; $display("FAIL addi_state c%0d got %0d exp %0d", c, state, st[c]); end
         n_cmp++; if (RFWr !== (c == 3))  begin n_err++; $display("FAIL addi_rfwr c%0d got %b exp %b", c, RFWr, c == 3); end
         if (c == 2) begin
            n_cmp++; if (ALUOp !== ALU_ADD || ALUSrc !== 1'b1) begin n_err++; $display("FAIL addi_ex got alu%0d src%b exp %0d 1", ALUOp, ALUSrc, ALU_ADD); end
         end
         if (c == 3) begin
            n_cmp++; if (instret !== exp_ret) begin n_err++; $display("FAIL addi_ret_before got %0d exp %0d", instret, exp_ret); end
         end
         if (c < 4) begin @(posedge clk); #1; end
      end
      exp_ret++;
      n_cmp++; if (instret !== exp_ret) begin n_err++; $display("FAIL addi_ret got %0d exp %0d", instret, exp_ret); end
   endtask

   task automatic test_lw_wait;
      int st[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
      op = OP_LW;
      for (int c = 0; c < 8; c++) begin
         dm_ready = !(c == 3 || c == 4);
         #1;
         n_cmp++; if (state !== 3'(st[c])) begin n_err++; $display("FAIL lw_state c%0d got %0d exp %0d", c, state, st[c]); end
         if (c >= 3 && c <= 5) begin
            n_cmp++; if (dm_req !== 1'b1 || DMRe !== DMRE_LW || ALUOp !== ALU_ADD || instr_done !== 1'b0)
                        begin n_err++; $display("FAIL lw_mem c%0d got dm%b dmre%0d alu%0d done%b exp 1 %0d %0d 0", c, dm_req, DMRe, DMRe, instr_done, DMRE_LW, ALU_ADD); end
         end
         if (c == 6) begin
            n_cmp++; if (ToReg !== DM2REG || RFWr !== 1'b1 || instr_done !== 1'b1 || RegDst !== RD_RT || dm_req !== 1'b0)
                        begin n_err++; $display("FAIL lw_wb got toreg%0d rfwr%b done%b rd%0d dm%b", ToReg, RFWr, instr_done, RegDst, dm_req); end
         end
         if (c < 7) begin @(posedge clk); #1; end
      end
      exp_ret++;
      n_cmp++; if (instret !== exp_ret) begin n_err++; $display("FAIL lw_ret got %0d exp %0d", instret, exp_ret); end
   endtask

   task automatic test_branch;
      logic [5:0] ops[3] = '{OP_BEQ, OP_BLTZ_BGEZ, OP_BLTZ_BGEZ};
      logic [4:0] bzs[3] = '{5'd0, 5'd0, 5'd1};
      logic [3:0] npc[3] = '{NPC_BRANCH_BEQ, NPC_BRANCH_BLTZ, NPC_BRANCH_BGEZ};
      logic [4:0] alu[3] = '{ALU_SUB, ALU_SUBZ, ALU_SUBZ};
      int st[4] = '{0, 1, 5, 0};
      for (int k = 0; k < 3; k++) begin
         op = ops[k]; bgez_bltz = bzs[k];
         for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (state !== 3'(st[c])) begin n_err++; $display("FAIL br%0d_state c%0d got %0d exp %0d", k, c, state, st[c]); end
            if (c == 2) begin
               n_cmp++; if (PCWrCond !== 1'b1 || PCWr !== 1'b0 || instr_done !== 1'b1)
                           begin n_err++; $display("FAIL br%0d_strobe got cond%b pcwr%b done%b exp 1 0 1", k, PCWrCond, PCWr, instr_done); end
               n_cmp++; if (NPCOp !== npc[k] || ALUOp !== alu[k])
                           begin n_err++; $display("FAIL br%0d_ops got npc%0d alu%0d exp %0d %0d", k, NPCOp, ALUOp, npc[k], alu[k]); end
            end
            if (c < 3) begin @(posedge clk); #1; end
         end
         exp_ret++;
         n_cmp++; if (instret !== exp_ret) begin n_err++; $display("FAIL br%0d_ret got %0d exp %0d", k, instret, exp_ret); end
      end
      bgez_bltz = 5'd0;
   endtask

   task automatic test_jump;
      logic [5:0] ops[3] = '{OP_JAL, OP_JALR_JR, OP_JALR_JR};
      logic [5:0] fns[3] = '{6'd0, F_JR, F_JALR};
      logic [3:0] npc[3] = '{NPC_JUMP, NPC_JUMPR, NPC_JUMPR};
      logic       rfw[3] = '{1'b1, 1'b0, 1'b1};
      logic [1:0] rd[3]  = '{RD_RA, RD_RT, RD_RD};
      int st[4] = '{0, 1, 6, 0};
      for (int k = 0; k < 3; k++) begin
         op = ops[k]; funct = fns[k];
         for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (state !== 3'(st[c])) begin n_err++; $display("FAIL jmp%0d_state c%0d got %0d exp %0d", k, c, state, st[c]); end
            if (c == 2) begin
               n_cmp++; if (PCWr !== 1'b1 || NPCOp !== npc[k] || RFWr !== rfw[k] || instr_done !== 1'b1)
                           begin n_err++; $display("FAIL jmp%0d_ctl got pcwr%b npc%0d rfwr%b done%b exp 1 %0d %b 1", k, PCWr, NPCOp, RFWr, instr_done, npc[k], rfw[k]); end
               if (rfw[k]) begin
                  n_cmp++; if (RegDst !== rd[k] || ToReg !== NPC2REG)
                              begin n_err++; $display("FAIL jmp%0d_wb got rd%0d toreg%0d exp %0d %0d", k, RegDst, ToReg, rd[k], NPC2REG); end
               end
            end
            if (c < 3) begin @(posedge clk); #1; end
         end
         exp_ret++;
         n_cmp++; if (instret !== exp_ret) begin n_err++; $display("FAIL jmp%0d_ret got %0d exp %0d", k, instret, exp_ret); end
      end
      funct = 6'd0;
   endtask

   task automatic test_fetch_wait;
      int st[8] = '{0, 0, 0, 0, 1, 2, 4, 0};
      op = OP_ORI;
      for (int c = 0; c < 8; c++) begin
         im_ready = (c >= 3);
         #1;
         n_cmp++; if (state !== 3'(st[c])) begin n_err++; $display("FAIL fw_state c%0d got %0d exp %0d", c, state, st[c]); end
         if (c <= 3) begin
            n_cmp++; if (im_req !== 1'b1 || IRWr !== (c == 3) || PCWr !== (c == 3))
                        begin n_err++; $display("FAIL fw_if c%0d got req%b irwr%b pcwr%b exp 1 %b %b", c, im_req, IRWr, PCWr, c == 3, c == 3); end
         end
         if (c == 5) begin
            n_cmp++; if (ALUOp !== ALU_OR || ALUSrc !== 1'b1) begin n_err++; $display("FAIL fw_ex got alu%0d src%b exp %0d 1", ALUOp, ALUSrc, ALU_OR); end
         end
         if (c < 7) begin @(posedge clk); #1; end
      end
      exp_ret++;  // ninth retire: 3-bit counter wraps to 1
      n_cmp++; if (instret !== exp_ret) begin n_err++; $display("FAIL fw_ret got %0d exp %0d", instret, exp_ret); end
   endtask

   task automatic test_illegal;
      int st[3] = '{0, 1, 0};
      op = 6'b111111;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (state !== 3'(st[c])) begin n_err++; $display("FAIL ill_state c%0d got %0d exp %0d", c, state, st[c]); end
         n_cmp++; if (illegal !== (c == 1)) begin n_err++; $display("FAIL ill_pulse c%0d got %b exp %b", c, illegal, c == 1); end
         n_cmp++; if (instr_done !== 1'b0) begin n_err++; $display("FAIL ill_done c%0d got %b exp 0", c, instr_done); end
         if (c < 2) begin @(posedge clk); #1; end
      end
      n_cmp++; if (instret !== exp_ret) begin n_err++; $display("FAIL ill_ret got %0d exp %0d", instret, exp_ret); end
   endtask

   task automatic test_rst_mid;
      int st[5] = '{0, 1, 2, 3, 0};
      op = OP_SW;
      for (int c = 0; c < 4; c++) begin
         dm_ready = (c < 3);
         #1;
         n_cmp++; if (state !== 3'(st[c])) begin n_err++; $display("FAIL sw_state c%0d got %0d exp %0d", c, state, st[c]); end
         if (c < 3) begin @(posedge clk); #1; end
      end
      n_cmp++; if (dm_req !== 1'b1 || DMWr !== DMWR_SW || instr_done !== 1'b0)
                  begin n_err++; $display("FAIL sw_mem_wait got dm%b dmwr%0d done%b exp 1 %0d 0", dm_req, DMWr, instr_done, DMWR_SW); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (dm_req !== 1'b0 || RFWr !== 1'b0 || instr_done !== 1'b0)
                  begin n_err++; $display("FAIL arst_strobes got dm%b rfwr%b done%b exp 0 0 0", dm_req, RFWr, instr_done); end
      n_cmp++; if (state !== 3'd0 || instret !== 3'd0 || im_req !== 1'b1)
                  begin n_err++; $display("FAIL arst_state got st%0d ret%0d req%b exp 0 0 1", state, instret, im_req); end
      @(posedge clk); #1;
      rst = 1'b0; dm_ready = 1'b1; exp_ret = 3'd0;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++; if (state !== 3'(st[c])) begin n_err++; $display("FAIL sw2_state c%0d got %0d exp %0d", c, state, st[c]); end
         if (c == 3) begin
            n_cmp++; if (instr_done !== 1'b1 || dm_req !== 1'b1 || RFWr !== 1'b0)
                        begin n_err++; $display("FAIL sw2_done got done%b dm%b rfwr%b exp 1 1 0", instr_done, dm_req, RFWr); end
         end
         if (c < 4) begin @(posedge clk); #1; end
      end
      exp_ret++;
      n_cmp++; if (instret !== exp_ret) begin n_err++; $display("FAIL sw2_ret got %0d exp %0d", instret, exp_ret); end
   endtask

   initial begin
      rst = 1'b1; im_ready = 1'b0; dm_ready = 1'b0;
      op = 6'd0; funct = 6'd0; bgez_bltz = 5'd0; exp_ret = 3'd0;
      test_reset;
      test_addi;
      test_lw_wait;
      test_branch;
      test_jump;
      test_fetch_wait;
      test_illegal;
      test_rst_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control sequencer for the MIPS core. It replaces the single-cycle decode path with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives the same control fields the datapath already consumes, using the `ctrl_encode_def.v` encodings, and adds ready/request handshakes to instruction and data memory so either memory may insert wait states. It also counts retired instructions.

## Interface
Parameters:
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  6  instruction [31:26], taken from the instruction register; stable from S_ID onward.
- funct  in  6  instruction [5:0].
- bgez_bltz  in  5  instruction [20:16]; selects BLTZ (5'b00000) or BGEZ.
- im_ready  in  1  instruction memory has data valid this cycle.
- dm_ready  in  1  data memory access completes this cycle.
- im_req  out  1  instruction read request.
- IRWr  out  1  instruction register load strobe.
- PCWr  out  1  unconditional PC write.
- PCWrCond  out  1  PC write qualified by the NPC branch condition.
- RegDst  out  2  `RD_*` destination select.
- ToReg  out  2  `ALU2REG` / `DM2REG` / `NPC2REG` write-back source.
- ALUSrc  out  1  1 selects the immediate.
- RFWr  out  1  register-file write strobe.
- NPCOp  out  4  `NPC_*` next-PC operation.
- ALUOp  out  5  `ALU_*` operation.
- dm_req  out  1  data memory request.
- DMWr  out  2  `DMWR_*` store type.
- DMRe  out  3  `DMRE_*` load type.
- state  out  3  current state, for debug.
- instr_done  out  1  one-cycle pulse on the final cycle of a legal instruction.
- illegal  out  1  one-cycle pulse when an unknown opcode is decoded.
- instret  out  INSTRET_W  retired-instruction count.

## Operation
State encodings: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4, S_BR=5, S_JMP=6. Encodings 7 and above are unreachable; if entered, go to S_IF.

Default outputs in every state, unless listed below:
- all strobes 0
- NPCOp=`NPC_PLUS4`, ALUOp=`ALU_NOP`
- DMWr=`DMWR_NOP`, DMRe=`DMRE_NOP`
- RegDst=`RD_RT`, ToReg=`ALU2REG`, ALUSrc=0

States:
- **S_IF**: im_req=1. While im_ready=0, hold in S_IF. When im_ready=1: IRWr=1, PCWr=1 (NPCOp=`NPC_PLUS4`), next state S_ID.
- **S_ID**: register operands are read.
  - R-type and all immediate ALU, load and store ops → S_EX.
  - BEQ, BNE, BGTZ, BLEZ, BLTZ_BGEZ → S_BR.
  - J, JAL, JALR_JR → S_JMP.
  - Any other op: illegal=1, → S_IF.
- **S_EX**:
  - ALUSrc: 0 for R-type, 1 for all others.
  - ALUOp per op:
    - R-type → `ALU_R`
    - ADDI, and all loads/stores → `ALU_ADD`
    - ADDIU → `ALU_ADDU`
    - ANDI → `ALU_AND`, ORI → `ALU_OR`, XORI → `ALU_XOR`
    - LUI → `ALU_LUI`
    - SLTI → `ALU_SLT`, SLTIU → `ALU_SLTU`
  - Next state: loads/stores → S_MEM; others → S_WB.
- **S_MEM**: dm_req=1, ALUOp=`ALU_ADD`, ALUSrc=1.
  - DMRe (loads) or DMWr (stores) carries the op-specific code.
  - All of these outputs are held constant until dm_ready=1.
  - On dm_ready=1: loads → S_WB; stores → S_IF with instr_done=1.
- **S_WB**: RFWr=1, instr_done=1, → S_IF.
  - R-type: RegDst=`RD_RD`, ToReg=`ALU2REG`.
  - Immediate ALU ops: RegDst=`RD_RT`, ToReg=`ALU2REG`.
  - Loads: RegDst=`RD_RT`, ToReg=`DM2REG`; DMRe is held at the load code.
- **S_BR**: PCWrCond=1, instr_done=1, → S_IF.
  - BEQ/BNE: ALUOp=`ALU_SUB`. BGTZ/BLEZ/BLTZ/BGEZ: ALUOp=`ALU_SUBZ`.
  - NPCOp is the matching `NPC_BRANCH_*`. BLTZ_BGEZ decodes bgez_bltz: 5'b00000 → BLTZ, else BGEZ.
- **S_JMP**: PCWr=1, instr_done=1, → S_IF.
  - J/JAL: NPCOp=`NPC_JUMP`. JALR_JR: NPCOp=`NPC_JUMPR`.
  - JAL: RFWr=1, RegDst=`RD_RA`, ToReg=`NPC2REG`.
  - JALR_JR with funct==`JALR`: RFWr=1, RegDst=`RD_RD`, ToReg=`NPC2REG`. JR: RFWr=0.

Retired-instruction counter:
- instret increments by 1 on each instr_done and wraps from 2^INSTRET_W−1 to 0.
- Illegal ops do not count.

## Timing
- Reset: state=S_IF, instret=0, all outputs at defaults. Since S_IF asserts im_req, im_req=1 immediately after reset; all other strobes are 0.
- rst asserted mid-instruction aborts it at once, asynchronously: dm_req, RFWr and all other strobes fall before the next clock edge.
- All outputs are a function of state and the registered op, funct and bgez_bltz fields, with two exceptions that also depend on the ready inputs in the same cycle:
  - IRWr and PCWr in S_IF depend on im_ready.
  - instr_done on stores depends on dm_ready.
- Latency with zero-wait memory (im_ready=dm_ready=1):
  - R-type / immediate ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch / jump: 3 cycles.
  - Illegal op: 2 cycles.
- Each im_ready=0 cycle in S_IF, or dm_ready=0 cycle in S_MEM, adds exactly one cycle.
- dm_ready or im_ready asserted outside S_MEM / S_IF is ignored.

## Test plan
- ADDI, both memories ready: state sequence 0,1,2,4,0. RFWr=1 only in the S_WB cycle. instret 0→1 at the edge leaving S_WB.
- LW with dm_ready low for 2 cycles: S_MEM lasts 3 cycles with dm_req=1 and DMRe=`DMRE_LW` stable throughout. Then S_WB with ToReg=`DM2REG`. Total 7 cycles.
- BEQ and BLTZ (bgez_bltz=0): 3 cycles.
  - BEQ: S_BR has PCWrCond=1, NPCOp=`NPC_BRANCH_BEQ`, ALUOp=`ALU_SUB`.
  - BLTZ: NPCOp=`NPC_BRANCH_BLTZ`, ALUOp=`ALU_SUBZ`.
- JAL, then JR:
  - JAL in S_JMP: PCWr=1, RFWr=1, RegDst=`RD_RA`, ToReg=`NPC2REG`.
  - JR in S_JMP: NPCOp=`NPC_JUMPR`, RFWr=0.
- Fetch wait: im_ready=0 for 3 cycles. im_req=1 and IRWr=0 throughout; IRWr and PCWr pulse together on the cycle im_ready=1.
- Unknown op 6'b111111: illegal pulses in S_ID, return to S_IF, instret unchanged. Separately, rst pulsed during S_MEM of SW: dm_req drops asynchronously, state=0, instret=0.
